// File: rtl/gemm_out_collector.sv
// Output-row collector for the bit-serial GEMM: mirrors the engine schedule, packs rows into
// ping-pong frames and streams them out. Optional ReLU on capture: define GEMM_COLLECT_RELU_EN.
module gemm_out_collector #(
  parameter int DATA_WIDTH_A   = 8,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int M              = 2,
  parameter int N              = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gen_done,
  input  logic [N*DATA_WIDTH_OUT-1:0]   final_out,
  input  logic                          clr_ovf,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*DATA_WIDTH_OUT-1:0]   out_data,
  output logic [7:0]                    out_row,
  output logic                          out_last,
  output logic                          overflow
);

  localparam int TW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam int RW = $clog2(M);

  logic [TW-1:0] t;
  logic [7:0]    m;
  logic [7:0]    cap_row;
  logic [7:0]    rd_row;
  logic          primed;
  logic          wr_bank;
  logic          rd_bank;
  logic          drop;
  logic [1:0]    full;
  logic [1:0]    full_nxt;

  logic signed [DATA_WIDTH_OUT-1:0] bank [2][M][N];

  logic capture;
  logic cap_last;
  logic drop_start;
  logic do_write;
  logic complete;
  logic beat;
  logic release_bank;

  function automatic logic signed [DATA_WIDTH_OUT-1:0] relu(
    input logic signed [DATA_WIDTH_OUT-1:0] x
  );
`ifdef GEMM_COLLECT_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  always_comb begin
    capture      = gen_done && primed && (t == '0);
    cap_last     = (cap_row == 8'(M-1));
    drop_start   = capture && (cap_row == 8'd0) && full[wr_bank];
    do_write     = capture && !drop && !drop_start && !full[wr_bank];
    complete     = do_write && cap_last;
    beat         = out_valid && out_ready;
    release_bank = beat && (rd_row == 8'(M-1));
    full_nxt     = full;
    if (release_bank) full_nxt[rd_bank] = 1'b0;
    if (complete)     full_nxt[wr_bank] = 1'b1;
  end

  // Stage p0: schedule mirror and frame/readout control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t        <= '0;
      m        <= '0;
      cap_row  <= '0;
      primed   <= 1'b0;
      rd_row   <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= 2'b00;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (gen_done) begin
        if (t == TW'(DATA_WIDTH_A-1)) begin
          t       <= '0;
          cap_row <= m;
          m       <= (m == 8'(M-1)) ? 8'd0 : m + 8'd1;
          primed  <= 1'b1;
        end else begin
          t <= t + TW'(1);
        end
      end

      full <= full_nxt;
      if (complete) wr_bank <= ~wr_bank;

      if (release_bank) begin
        rd_row  <= '0;
        rd_bank <= ~rd_bank;
      end else if (beat) begin
        rd_row <= rd_row + 8'd1;
      end

      // A dropped frame is swallowed through its final row capture
      if (drop_start)                   drop <= 1'b1;
      else if (capture && drop && cap_last) drop <= 1'b0;

      if (drop_start)   overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Stage p1: row storage, data path only (no reset)
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int j = 0; j < N; j++) begin
        bank[wr_bank][cap_row[RW-1:0]][j] <=
          relu($signed(final_out[j*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]));
      end
    end
  end

  always_comb begin
    out_valid = full[rd_bank];
    out_row   = rd_row;
    out_last  = (rd_row == 8'(M-1));
    out_data  = '0;
    for (int j = 0; j < N; j++) begin
      if (out_valid)
        out_data[j*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = bank[rd_bank][rd_row[RW-1:0]][j];
    end
  end

endmodule

// File: tb/tb_gemm_out_collector.sv
// Randomized scoreboard bench for gemm_out_collector (M=2, N=4, DATA_WIDTH_A=8, DATA_WIDTH_OUT=8).
module tb_gemm_out_collector;

  localparam int DWA = 8;
  localparam int W   = 8;
  localparam int M   = 2;
  localparam int N   = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           gen_done;
  logic [N*W-1:0] final_out;
  logic           clr_ovf;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic [7:0]     out_row;
  logic           out_last;
  logic           overflow;

  gemm_out_collector #(
    .DATA_WIDTH_A(DWA), .DATA_WIDTH_OUT(W), .M(M), .N(N)
  ) dut (
    .clk(clk), .rst(rst), .gen_done(gen_done), .final_out(final_out),
    .clr_ovf(clr_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] data;
    logic [7:0]     row;
    logic           last;
  } beat_t;

  beat_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: frames are counted in whole gen_done cycles since reset.
  int             k;
  int             occ;
  int             rd_beat;
  bit             dropping;
  bit             exp_ovf;
  bit             exp_valid;
  logic [N*W-1:0] cur [M];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [N*W-1:0] r;
    r[7:0]   = 8'(a);
    r[15:8]  = 8'(b);
    r[23:16] = 8'(c);
    r[31:24] = 8'(d);
    return r;
  endfunction

  function automatic logic [N*W-1:0] relu_row(input logic [N*W-1:0] v);
    logic [N*W-1:0] r;
    r = v;
`ifdef GEMM_COLLECT_RELU_EN
    for (int j = 0; j < N; j++)
      if ($signed(v[j*W +: W]) < 0) r[j*W +: W] = '0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    k = 0; occ = 0; rd_beat = 0; dropping = 0; exp_ovf = 0; exp_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit gd, input logic [N*W-1:0] fo, input bit rdy, input bit clr);
    int  occ0;
    int  row;
    bit  rel;
    bit  add;
    occ0 = occ; rel = 0; add = 0;
    if (rdy && occ0 > 0) begin
      rd_beat++;
      if (rd_beat == M) begin rd_beat = 0; rel = 1; end
    end
    if (clr) exp_ovf = 0;
    if (gd) begin
      if (k >= DWA && (k % DWA) == 0) begin
        row = (k / DWA - 1) % M;
        if (row == 0 && occ0 == 2) begin dropping = 1; exp_ovf = 1; end
        if (dropping) begin
          if (row == M-1) dropping = 0;
        end else begin
          cur[row] = relu_row(fo);
          if (row == M-1) begin
            add = 1;
            for (int r = 0; r < M; r++) begin
              beat_t b;
              b.data = cur[r]; b.row = 8'(r); b.last = (r == M-1);
              exp_q.push_back(b);
            end
          end
        end
      end
      k++;
    end
    occ = occ0 + int'(add) - int'(rel);
    exp_valid = (occ > 0);
  endtask

  task automatic step(input bit gd, input logic [N*W-1:0] fo, input bit rdy, input bit clr);
    @(negedge clk);
    gen_done = gd; final_out = fo; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    model_edge(gd, fo, rdy, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    #1 chk("valid_after_async_rst", 64'(out_valid), 64'd0);
    model_reset();
    gen_done = 0; out_ready = 0; clr_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares presented beats against the scoreboard head, pops on handshake
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_queue_size", 64'd0, 64'd1);
          end else begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].data));
            chk("out_row",  64'(out_row),  64'(exp_q[0].row));
            chk("out_last", 64'(out_last), 64'(exp_q[0].last));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] fo;
    rst = 1'b1; gen_done = 0; final_out = '0; out_ready = 0; clr_ovf = 0;
    model_reset();
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_row",   64'(out_row),   64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, priming and ReLU vectors
    for (int i = 0; i < 44; i++) begin
      fo = N*W'($urandom);
      if (i == 0)  fo = pack4(9, 9, 9, 9);
      if (i == 8)  fo = pack4(1, 2, 3, 4);
      if (i == 16) fo = pack4(5, 6, 7, 8);
      if (i == 24) fo = pack4(-3, 4, -128, 127);
      if (i == 32) fo = pack4(-1, -2, 0, 1);
      step(1'b1, fo, 1'b1, 1'b0);
    end

    // Backpressure until a frame is dropped, then release with gen_done low
    do_reset();
    for (int i = 0; i < 60; i++) step(1'b1, N*W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  step(1'b0, N*W'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Stall: gen_done low for cycles 5..9
    do_reset();
    for (int i = 0; i < 40; i++)
      step(!(i >= 5 && i <= 9), N*W'($urandom), 1'b1, 1'b0);

    // Reset mid-readout after the first beat
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, N*W'($urandom), 1'b0, 1'b0);
    step(1'b1, N*W'($urandom), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, N*W'($urandom), 1'b1, 1'b0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) != 0, N*W'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end

    // Drain
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
